// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the opcode constants, the encoder FSM state type and the canonical
// NOP word (addi x0,x0,0). Unknown opcodes are replaced by this NOP.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } enc_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the encoded-word output buffer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointers/level only)
//   push, wdata   write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   rdata         head-of-queue word (valid while !empty)
//   empty         no entries buffered
//   level         number of buffered entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_push = push && (level != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the level unchanged.
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I program encoder: accepts instruction field tuples, encodes them into
// 32-bit words and streams them, with consecutive byte addresses, toward an
// instruction memory.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, base_addr, count    run request (accepted only when idle)
//   in_valid/in_ready          field-tuple handshake
//   opcode..imm                instruction fields
//   out_valid/out_ready        encoded-word handshake
//   out_instr, out_addr        encoded word and its byte address
//   busy, done, err            status: not idle, completion pulse, sticky bad opcode
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  enc_state_t        state, next_state;
  logic [15:0]       remaining;
  logic [31:0]       addr;
  logic [31:0]       enc_p1;
  logic              vld_p1;
  logic [31:0]       fifo_rdata;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W:0]    pending;
  logic              start_ok;
  logic              in_fire;
  logic              out_fire;

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM,
      OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rdst,
    input logic [31:0] im
  );
    case (op)
      OP_R:      return {f7, r2, r1, f3, rdst, op};
      OP_IMM: begin
        // Shift-immediates carry func7 in the upper bits and a 5-bit shamt.
        if (f3 == 3'b001 || f3 == 3'b101) return {f7, im[4:0], r1, f3, rdst, op};
        else                              return {im[11:0], r1, f3, rdst, op};
      end
      OP_LOAD, OP_JALR, OP_SYSTEM:
                 return {im[11:0], r1, f3, rdst, op};
      OP_STORE:  return {im[11:5], r2, r1, f3, im[4:0], op};
      OP_BRANCH: return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], op};
      OP_LUI, OP_AUIPC:
                 return {im[31:12], rdst, op};
      OP_JAL:    return {im[20], im[10:1], im[11], im[19:12], rdst, op};
      default:   return NOP_INSTR;
    endcase
  endfunction

  assign start_ok = start && (state == S_IDLE);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Credit check counts the word still in the encode register so the FIFO
  // can never be asked to take more than it holds.
  assign pending  = {1'b0, fifo_level} + (LVL_W+1)'(vld_p1);
  assign in_ready = (state == S_RUN) && (remaining != 16'd0)
                    && (pending < (LVL_W+1)'(FIFO_DEPTH));

  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? fifo_rdata : 32'd0;
  assign out_addr  = addr;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      addr      <= '0;
      err       <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state  <= next_state;
      vld_p1 <= in_fire;
      if (start_ok) begin
        remaining <= count;
        addr      <= base_addr;
        err       <= 1'b0;
      end else begin
        if (in_fire) begin
          remaining <= remaining - 16'd1;
          if (!known_op(opcode)) err <= 1'b1;
        end
        if (out_fire) addr <= addr + 32'd4;
      end
    end
  end

  // ---- stage p1: encoded word registered ahead of the output FIFO ----
  always_ff @(posedge clk) begin
    if (in_fire) enc_p1 <= encode(opcode, func3, func7, rs1, rs2, rd, imm);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_ok) next_state = (count == 16'd0) ? S_DONE : S_RUN;
      S_RUN:   if (in_fire && remaining == 16'd1) next_state = S_FLUSH;
      S_FLUSH: if (out_fire && fifo_level == LVL_W'(1) && !vld_p1) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // ---- stage p2: output buffer ----
  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .wdata (enc_p1),
    .pop   (out_fire),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule
